// File: rtl/alu_seq.sv
// alu_seq: registered ALU with internal architectural flags (C/Z/N/V) and an
// iterative one-bit-per-cycle shifter behind a valid/ready input handshake.
// Non-shift ops finish at the accept edge. Shifts with count n>=1 take n edges:
// the first step happens at the accept edge and the rest happen in SHIFT.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SC_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fn,
    input  logic [SC_W-1:0]  sc,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBC = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_MASK = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_ROL  = 4'd10,
        OP_ROR  = 4'd11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] y_q;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] w_q;
    logic [SC_W-1:0]  cnt_q;
    logic [1:0]       kind_q;

    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH:0]   first_step;
    logic [WIDTH:0]   next_step;
    logic             is_shift;
    logic             acc_long;
    logic [WIDTH-1:0] imm_y_d;
    logic             imm_c_d;
    logic             imm_o_d;
    logic             imm_upd_d;

    // One shifter step on w; returns {carry_out, new_w}.
    // kind: 00 SHL, 01 SHR, 10 ROL, 11 ROR (low two opcode bits).
    function automatic logic [WIDTH:0] shift_step(input logic [1:0] kind,
                                                  input logic [WIDTH-1:0] w);
        logic [WIDTH:0] r;
        case (kind)
            2'b00:   r = {w[MSB], w[MSB-1:0], 1'b0};
            2'b01:   r = {w[0], 1'b0, w[MSB:1]};
            2'b10:   r = {w[MSB], w[MSB-1:0], w[MSB]};
            default: r = {w[0], w[0], w[MSB:1]};
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

    // Adder/subtractor and shifter steps for the current request and working register.
    always_comb begin
        cin        = ((fn == OP_ADDC) || (fn == OP_SUBC)) ? cout_q : 1'b0;
        sum        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        add_ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        sub_ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        first_step = shift_step(fn[1:0], a);
        next_step  = shift_step(kind_q, w_q);
        is_shift   = (fn[3:2] == 2'b10);
        acc_long   = is_shift && (sc > SC_W'(1));
    end

    // Result and flags for an op that completes at its accept edge.
    always_comb begin
        imm_y_d   = y_q;
        imm_c_d   = cout_q;
        imm_o_d   = 1'b0;
        imm_upd_d = 1'b1;
        case (fn)
            OP_ADD, OP_ADDC: begin
                imm_y_d = sum[MSB:0];
                imm_c_d = sum[WIDTH];
                imm_o_d = add_ovf;
            end
            OP_SUB, OP_SUBC: begin
                imm_y_d = diff[MSB:0];
                imm_c_d = diff[WIDTH];
                imm_o_d = sub_ovf;
            end
            OP_AND:  imm_y_d = a & b;
            OP_OR:   imm_y_d = a | b;
            OP_XOR:  imm_y_d = a ^ b;
            OP_MASK: imm_y_d = a & ~b;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                if (sc == '0) begin
                    imm_y_d = a;
                end else begin
                    imm_y_d = first_step[MSB:0];
                    imm_c_d = first_step[WIDTH];
                end
            end
            default: imm_upd_d = 1'b0;
        endcase
    end

    // Control FSM with registered result, flags and out_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            y_q         <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            w_q         <= '0;
            cnt_q       <= '0;
            kind_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (acc_long) begin
                            state_q <= S_SHIFT;
                            w_q     <= first_step[MSB:0];
                            cnt_q   <= sc - SC_W'(1);
                            kind_q  <= fn[1:0];
                        end else begin
                            out_valid_q <= 1'b1;
                            if (imm_upd_d) begin
                                y_q    <= imm_y_d;
                                cout_q <= imm_c_d;
                                zero_q <= (imm_y_d == '0);
                                neg_q  <= imm_y_d[MSB];
                                ovf_q  <= imm_o_d;
                            end
                        end
                    end
                end
                default: begin
                    // cnt_q counts steps still to do; the final step commits to y.
                    w_q   <= next_step[MSB:0];
                    cnt_q <= cnt_q - SC_W'(1);
                    if (cnt_q == SC_W'(1)) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        y_q         <= next_step[MSB:0];
                        cout_q      <= next_step[WIDTH];
                        zero_q      <= (next_step[MSB:0] == '0);
                        neg_q       <= next_step[MSB];
                        ovf_q       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
